// File: rtl/aes_seq_pkg.sv
// Shared types for the AES job sequencer: FSM state encoding and key-size decode.
package aes_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY_GO,
        KEY_WAIT,
        DATA_WAIT,
        RES_WAIT,
        DONE,
        ERR
    } seq_state_t;

    localparam logic [2:0] NK_SEL_128 = 3'b011;
    localparam logic [2:0] NK_SEL_192 = 3'b101;
    localparam logic [2:0] NK_SEL_256 = 3'b111;

    typedef struct packed {
        logic       valid;
        logic [3:0] nk_val;
        logic [3:0] nr;
    } nk_decode_t;

    function automatic nk_decode_t decode_nk_sel(input logic [2:0] sel);
        nk_decode_t d;
        d = '{valid: 1'b0, nk_val: 4'd4, nr: 4'd10};
        case (sel)
            NK_SEL_128: d = '{valid: 1'b1, nk_val: 4'd4, nr: 4'd10};
            NK_SEL_192: d = '{valid: 1'b1, nk_val: 4'd6, nr: 4'd12};
            NK_SEL_256: d = '{valid: 1'b1, nk_val: 4'd8, nr: 4'd14};
            default:    d = '{valid: 1'b0, nk_val: 4'd4, nr: 4'd10};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/aes_job_sequencer_if.sv
// Host/core handshake bundle of the AES job sequencer; slave is the sequencer side.
interface aes_job_sequencer_if;
    logic       start;
    logic       ed;
    logic [2:0] nk_sel;
    logic       key_wr;
    logic       k_done;
    logic       core_full;
    logic       c_ready;
    logic       k_start;
    logic [3:0] nk_val;
    logic [3:0] nr;
    logic       t_valid;
    logic       op;
    logic       rt_load;
    logic       ok;
    logic       err;
    logic       busy;

    modport master (
        output start, ed, nk_sel, key_wr, k_done, core_full, c_ready,
        input  k_start, nk_val, nr, t_valid, op, rt_load, ok, err, busy
    );

    modport slave (
        input  start, ed, nk_sel, key_wr, k_done, core_full, c_ready,
        output k_start, nk_val, nr, t_valid, op, rt_load, ok, err, busy
    );
endinterface

// File: rtl/aes_seq_timer.sv
// Wait-state watchdog: counts cycles spent in one wait state, flags the last allowed cycle.
module aes_seq_timer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 12
) (
    input  logic CLK,
    input  logic RSTB,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Asserted in the final waiting cycle so the FSM lands in ERR exactly TIMEOUT_CYCLES after entry.
    assign expired = count_en && (cnt_reg == LAST_CNT);

    always_comb begin
        cnt_next = cnt_reg;
        if (clear)
            cnt_next = '0;
        else if (count_en)
            cnt_next = cnt_reg + 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end
endmodule

// File: rtl/aes_job_sequencer.sv
// Runs one host AES job: key-size check, optional key expansion, one block through the core.
// Build option AES_SEQ_TIMEOUT_EN adds a per-wait-state watchdog that aborts to ERR.
module aes_job_sequencer
    import aes_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 12
) (
    input logic                CLK,
    input logic                RSTB,
    aes_job_sequencer_if.slave bus
);
    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    seq_state_t state_reg, state_next;
    logic       start_q_reg;
    logic       key_stale_reg, key_stale_next;
    logic       op_reg;
    logic [3:0] nk_val_reg, nr_reg;
    logic       start_rise;
    logic       timeout_hit;
    nk_decode_t dec;

    assign start_rise = bus.start & ~start_q_reg;
    assign dec        = decode_nk_sel(bus.nk_sel);

`ifdef AES_SEQ_TIMEOUT_EN
    logic in_wait;
    assign in_wait = (state_reg == KEY_WAIT) || (state_reg == DATA_WAIT) || (state_reg == RES_WAIT);

    aes_seq_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .clear    (state_next != state_reg),
        .count_en (in_wait),
        .expired  (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_rise) begin
                    if (!dec.valid)
                        state_next = ERR;
                    else if (key_stale_reg)
                        state_next = KEY_GO;
                    else
                        state_next = DATA_WAIT;
                end
            end
            KEY_GO:    state_next = KEY_WAIT;
            KEY_WAIT:  if (bus.k_done)     state_next = DATA_WAIT;
            DATA_WAIT: if (!bus.core_full) state_next = RES_WAIT;
            RES_WAIT:  if (bus.c_ready)    state_next = DONE;
            DONE:      if (!bus.start)     state_next = IDLE;
            ERR:       if (!bus.start)     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        if (timeout_hit)
            state_next = ERR;
    end

    always_comb begin
        bus.k_start = (state_reg == KEY_GO);
        bus.t_valid = (state_reg == DATA_WAIT) && !bus.core_full && !timeout_hit;
        bus.rt_load = (state_reg == RES_WAIT) && bus.c_ready && !timeout_hit;
        bus.ok      = (state_reg == DONE);
        bus.err     = (state_reg == ERR);
        bus.busy    = (state_reg != IDLE) && (state_reg != DONE);
        bus.op      = op_reg;
        bus.nk_val  = nk_val_reg;
        bus.nr      = nr_reg;
    end

    // A key write always wins over the clear, so a write racing expansion forces a re-expand next job.
    always_comb begin
        key_stale_next = key_stale_reg;
        if (bus.key_wr || timeout_hit)
            key_stale_next = 1'b1;
        else if (state_reg == KEY_GO)
            key_stale_next = 1'b0;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            start_q_reg   <= 1'b0;
            key_stale_reg <= 1'b1;
            op_reg        <= 1'b0;
            nk_val_reg    <= 4'd4;
            nr_reg        <= 4'd10;
        end else begin
            start_q_reg   <= bus.start;
            key_stale_reg <= key_stale_next;
            if ((state_reg == IDLE) && start_rise) begin
                op_reg <= bus.ed;
                if (dec.valid) begin
                    nk_val_reg <= dec.nk_val;
                    nr_reg     <= dec.nr;
                end
            end
        end
    end
endmodule

// File: doc/aes_job_sequencer.md
Name: aes_job_sequencer

Overview:
- Single-clock controller that runs one host AES job end to end: validate the key-size code, run or skip key expansion, hand one 128-bit block to the encrypt/decrypt core under back-pressure, capture the result, then raise OK.
- Sits between the host register file (key/text/config bytes) and the key-expansion and cipher cores.
- Replaces free-running level-based strobing with explicit handshakes.

Parameters:
- TIMEOUT_CYCLES, 4096: max cycles spent in any wait state before abort (only with AES_SEQ_TIMEOUT_EN).
- CNT_W, 12: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock
- RSTB  in  1  asynchronous active-low reset
- start  in  1  host START level; a job begins on its rising edge (sampled in CLK domain)
- ed  in  1  1 = encrypt, 0 = decrypt
- nk_sel  in  3  key-size code: 3'b011 = 128-bit, 3'b101 = 192-bit, 3'b111 = 256-bit
- key_wr  in  1  pulse on any host write to key bytes or nk_sel; marks the expanded key stale
- k_done  in  1  key-expansion core finished (level or pulse)
- core_full  in  1  cipher core cannot accept a block
- c_ready  in  1  result valid from cipher core
- k_start  out  1  one-cycle pulse: start key expansion
- nk_val  out  4  4, 6 or 8
- nr  out  4  10, 12 or 14
- t_valid  out  1  one-cycle pulse: plaintext block presented to core
- op  out  1  registered copy of ed, latched at job start
- rt_load  out  1  one-cycle pulse: RT register bank captures the core result
- ok  out  1  job complete
- err  out  1  job aborted: bad nk_sel (or timeout)
- busy  out  1  high in every state except IDLE and DONE

Behaviour:
- Reset values: every output 0, except nk_val = 4 and nr = 10. Internal key_stale = 1. State = IDLE.
- start edge detector: registered previous value; start_rise = start & ~start_q.
- States and transitions:
  - IDLE: on start_rise, latch op <= ed, decode nk_sel into nk_val/nr.
    - Invalid code: go to ERR.
    - key_stale = 1: go to KEY_GO.
    - Otherwise: go to DATA_WAIT (key reuse).
  - KEY_GO: k_start = 1 for one cycle; clear key_stale; go to KEY_WAIT.
  - KEY_WAIT: stay until k_done = 1, then go to DATA_WAIT.
  - DATA_WAIT: stay while core_full = 1. When core_full = 0, pulse t_valid that same cycle and go to RES_WAIT.
  - RES_WAIT: stay until c_ready = 1; then pulse rt_load and go to DONE.
  - DONE: ok = 1; return to IDLE when start = 0, clearing ok in that transition.
  - ERR: err = 1; return to IDLE when start = 0, clearing err.
- Latency with the key reused and no stalls: start_rise at cycle 0, t_valid at cycle 1, rt_load in the cycle c_ready is first seen, ok the next cycle.
- nr/nk_val hold their value from job start until the next job start.
- key_wr sets key_stale in any state. If key_wr arrives during KEY_WAIT, key_stale stays set: the current job uses the old expansion, and the next job re-expands.
- key_wr and the KEY_GO clear in the same cycle: set wins.
- start_rise while not in IDLE is ignored; there is no job queueing.
- start held high continuously does not retrigger; a new job needs a low then a high.
- c_ready asserted in DATA_WAIT is ignored (stale result).
- Asynchronous reset mid-job returns everything to reset values. The next job always re-expands the key.

Optional Feature:
- Macro: AES_SEQ_TIMEOUT_EN.
- Defined: a counter clears on every state change and increments in KEY_WAIT, DATA_WAIT and RES_WAIT. On reaching TIMEOUT_CYCLES it forces ERR and sets key_stale.
- Undefined: no counter; waits are unbounded, and err is raised only for an invalid nk_sel.

Decomposition:
- Package aes_seq_pkg holds:
  - State enum: IDLE, KEY_GO, KEY_WAIT, DATA_WAIT, RES_WAIT, DONE, ERR.
  - nk_sel code constants.
  - Function decoding nk_sel to {valid, nk_val, nr}.
- One sub-module, aes_seq_timer: the timeout counter, instantiated only under AES_SEQ_TIMEOUT_EN.
- FSM and edge detector stay in the top level.

Test Plan:
- Fresh reset, nk_sel = 3'b011, ed = 1, start rises, k_done after 5 cycles, c_ready 20 cycles after t_valid -> k_start one pulse, nk_val = 4, nr = 10, op = 1, t_valid one pulse, rt_load one pulse, ok = 1 until start falls.
- Second job with no key_wr, nk_sel = 3'b111 -> no k_start, t_valid the cycle after start_rise, nk_val = 8, nr = 14.
- core_full held high for 10 cycles in DATA_WAIT -> t_valid delayed until the first cycle with core_full = 0; exactly one pulse.
- nk_sel = 3'b100 -> err = 1, no k_start or t_valid, err clears when start goes low.
- key_wr during KEY_WAIT, then a further job -> second job issues k_start again.
- With AES_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 16, c_ready never arrives -> err = 1 exactly 16 cycles after entering RES_WAIT, no rt_load; RSTB pulse mid-RES_WAIT -> all outputs return to reset values immediately.
